// File: rtl/snes_to_md_pad_reader.sv
// Polls a SNES pad over latch/clock/data and presents remapped, registered active-low buttons to the MD encoder.
// Frame = 34*HALF_CYC cycles every POLL_CYC idle cycles; no backpressure, outputs change only at frame end.
module snes_to_md_pad_reader #(
  parameter int HALF_CYC = 120,
  parameter int POLL_CYC = 333333
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic up,
  output logic dw,
  output logic lf,
  output logic rg,
  output logic a,
  output logic b,
  output logic c,
  output logic st,
  output logic x,
  output logic y,
  output logic z,
  output logic md,
  output logic pad_present,
  output logic frame_done
);

  localparam int MAXC = (POLL_CYC > 2*HALF_CYC) ? POLL_CYC : 2*HALF_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2*HALF_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_UPDATE
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [15:0]   r_shift, w_shift_nxt;
  logic [11:0]   r_btn, w_btn_nxt;
  logic          r_present, w_present_nxt;
  logic          r_sync1, r_sync2;
  logic          r_pad_latch, r_pad_clk, r_frame_done;
  logic          w_valid;

  assign w_valid = &r_shift[15:12];

  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_btn_nxt     = r_btn;
    w_present_nxt = r_present;
    case (r_state)
      S_IDLE: begin
        if (r_cnt == POLL_LAST) begin
          w_next    = S_LATCH;
          w_cnt_nxt = '0;
        end
      end
      S_LATCH: begin
        if (r_cnt == LATCH_LAST) begin
          w_next    = S_SHIFT_LO;
          w_cnt_nxt = '0;
          w_idx_nxt = 4'd0;
        end
      end
      S_SHIFT_LO: begin
        // Sampled HALF_CYC cycles after the previous pad edge, which covers the synchronizer delay.
        if (r_cnt == HALF_LAST) begin
          w_shift_nxt[r_idx] = r_sync2;
          w_next             = S_SHIFT_HI;
          w_cnt_nxt          = '0;
        end
      end
      S_SHIFT_HI: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == 4'd15) begin
            w_next = S_UPDATE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
            w_next    = S_SHIFT_LO;
          end
        end
      end
      S_UPDATE: begin
        w_next        = S_IDLE;
        w_cnt_nxt     = '0;
        w_present_nxt = w_valid;
        // Order: up dw lf rg a b c st x y z md
        w_btn_nxt = w_valid ? {r_shift[4], r_shift[5], r_shift[6], r_shift[7],
                               r_shift[1], r_shift[0], r_shift[8], r_shift[3],
                               r_shift[10], r_shift[9], r_shift[11], r_shift[2]}
                            : 12'hFFF;
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= 4'd0;
      r_shift      <= 16'hFFFF;
      r_btn        <= 12'hFFF;
      r_present    <= 1'b0;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_pad_latch  <= 1'b0;
      r_pad_clk    <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_btn        <= w_btn_nxt;
      r_present    <= w_present_nxt;
      r_sync1      <= pad_data;
      r_sync2      <= r_sync1;
      r_pad_latch  <= (w_next == S_LATCH);
      r_pad_clk    <= (w_next != S_SHIFT_LO);
      r_frame_done <= (w_next == S_UPDATE);
    end
  end

  assign {up, dw, lf, rg, a, b, c, st, x, y, z, md} = r_btn;
  assign pad_present = r_present;
  assign pad_latch   = r_pad_latch;
  assign pad_clk     = r_pad_clk;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_snes_to_md_pad_reader.sv
// Bench for snes_to_md_pad_reader: behavioural SNES pad, table-driven button model, directed and random frames.
module tb_snes_to_md_pad_reader;
  localparam int H = 4;
  localparam int P = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic pad_data;
  logic pad_latch, pad_clk;
  logic up, dw, lf, rg, a, b, c, st, x, y, z, md;
  logic pad_present, frame_done;
  logic [11:0] outs;

  always #5 clk = ~clk;

  snes_to_md_pad_reader #(.HALF_CYC(H), .POLL_CYC(P)) u_dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .up(up), .dw(dw), .lf(lf), .rg(rg),
    .a(a), .b(b), .c(c), .st(st), .x(x), .y(y), .z(z), .md(md),
    .pad_present(pad_present), .frame_done(frame_done)
  );

  assign outs = {up, dw, lf, rg, a, b, c, st, x, y, z, md};

  // Pad: latch restarts at bit 0, each pad_clk rise presents the next bit.
  logic [15:0] pad_word  = 16'hFFFF;
  logic [4:0]  pidx      = 5'd0;
  logic        noise_on  = 1'b0;
  logic        noise_val = 1'b1;
  logic        in_shift  = 1'b0;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pidx <= 5'd0;
    else if (pidx != 5'd16) pidx <= pidx + 5'd1;
  end

  always @(negedge clk) begin
    noise_val <= (($urandom & 32'd1) != 32'd0);
    if (frame_done || pad_latch) in_shift <= 1'b0;
    else if (!pad_clk) in_shift <= 1'b1;
  end

  always_comb begin
    pad_data = 1'b1;
    if (noise_on && !in_shift) pad_data = noise_val;
    else if (pidx < 5'd16) pad_data = pad_word[pidx[3:0]];
  end

  // Output order up dw lf rg a b c st x y z md, each taken from a SNES bit index.
  function automatic logic [11:0] model(input logic [15:0] w);
    int src [12] = '{4, 5, 6, 7, 1, 0, 8, 3, 10, 9, 11, 2};
    logic [11:0] r;
    r = 12'hFFF;
    if (&w[15:12])
      for (int i = 0; i < 12; i++) r[11-i] = w[src[i]];
    return r;
  endfunction

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [11:0] exp_outs = 12'hFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until frame_done (sampled on negedges), measuring the pad waveform on the way.
  task automatic run_frame(input logic [11:0] prev, output int lat, output int lo, output int pulses,
                           output int dly, output bit stable, output bit timeout);
    bit   seen;
    logic pc;
    lat = 0; lo = 0; pulses = 0; dly = 0; stable = 1; timeout = 1; seen = 0; pc = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (pad_latch) begin lat++; seen = 1; end
      if (seen) dly++;
      if (!pad_clk) lo++;
      if (pc && !pad_clk) pulses++;
      pc = pad_clk;
      if (outs !== prev) stable = 0;
      if (frame_done) begin timeout = 0; break; end
    end
  endtask

  task automatic do_frame(input logic [15:0] w, input string tag);
    int lat, lo, pulses, dly;
    bit stable, timeout;
    pad_word = w;
    run_frame(exp_outs, lat, lo, pulses, dly, stable, timeout);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_latch_len"}, 32'(lat), 32'(2*H));
    chk({tag, "_clk_low_total"}, 32'(lo), 32'(16*H));
    chk({tag, "_clk_pulses"}, 32'(pulses), 32'd16);
    chk({tag, "_done_delay"}, 32'(dly - 1), 32'(34*H));
    chk({tag, "_stable_until_done"}, 32'(stable), 32'd1);
    @(negedge clk);
    exp_outs = model(w);
    chk({tag, "_outs"}, 32'(outs), 32'(exp_outs));
    chk({tag, "_present"}, 32'(pad_present), 32'(&w[15:12]));
  endtask

  initial begin
    int   n, falls;
    bit   ok;
    logic pc;
    logic [15:0] w;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outs", 32'(outs), 32'hFFF);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_clk", 32'(pad_clk), 32'd1);
    chk("rst_present", 32'(pad_present), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_frame(16'hFFFF, "released");
    do_frame(16'hFFF5, "y_start");
    chk("y_start_a", 32'(a), 32'd0);
    chk("y_start_st", 32'(st), 32'd0);
    do_frame(16'hFFFF, "release_again");
    do_frame(16'h0FEF, "bad_id_up");
    chk("bad_id_up_up", 32'(up), 32'd1);
    for (int bi = 0; bi < 12; bi++) begin
      w = 16'hFFFF;
      w[bi] = 1'b0;
      do_frame(w, $sformatf("single_b%0d", bi));
      chk($sformatf("single_b%0d_one_low", bi), 32'($countones(~outs)), 32'd1);
    end

    // Reset in the middle of bit 7 of a frame carrying Up.
    do_frame(16'hFFEF, "up_pre");
    falls = 0; ok = 0; pc = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
      if (falls == 8) begin ok = 1; break; end
    end
    chk("midrst_reach_bit7", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs), 32'hFFF);
    chk("midrst_latch", 32'(pad_latch), 32'd0);
    chk("midrst_clk", 32'(pad_clk), 32'd1);
    chk("midrst_present", 32'(pad_present), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (frame_done) break;
    end
    chk("midrst_first_done", 32'(n), 32'(P + 34*H));
    chk("midrst_outs_hold", 32'(outs), 32'hFFF);
    @(posedge clk);
    #1;
    exp_outs = model(16'hFFEF);
    chk("midrst_up_after", 32'(up), 32'd0);
    chk("midrst_outs_after", 32'(outs), 32'(exp_outs));

    // Random frames with pad_data noise during IDLE and LATCH.
    noise_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      w = 16'($urandom);
      if ($urandom_range(3) != 0) w[15:12] = 4'hF;
      do_frame(w, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/snes_to_md_pad_reader.md
Name: snes_to_md_pad_reader

Overview:
- Upstream stage of md_sixbutton_encoder in the SNES-pad-to-Mega-Drive adapter.
- Periodically polls a SNES controller (latch/clock/serial data), validates the frame and remaps the buttons.
- Drives the encoder's twelve active-low button inputs (up, dw, lf, rg, a, b, c, st, x, y, z, md) from registered outputs.

Parameters:
HALF_CYC, 120, clk cycles per half bit period (6 us at 20 MHz); minimum 4
POLL_CYC, 333333, clk cycles spent in IDLE between frames (~60 Hz at 20 MHz); minimum 1

Ports:
clk  in  1  system clock, 20 MHz
rst_n  in  1  asynchronous active-low reset
pad_data  in  1  SNES serial data; low = pressed; asynchronous
pad_latch  out  1  SNES latch strobe, active high
pad_clk  out  1  SNES shift clock, idles high
up, dw, lf, rg  out  1 each  directions to encoder; low = pressed
a, b, c, st, x, y, z, md  out  1 each  buttons to encoder; low = pressed
pad_present  out  1  high while the last frame was valid
frame_done  out  1  one-cycle pulse when a frame completes (valid or not)

Behaviour:
- Reset: all twelve button outputs 1, pad_latch 0, pad_clk 1, pad_present 0, frame_done 0; FSM in IDLE with counters cleared; synchronizer flops set to 1.
- pad_data passes a 2-FF synchronizer before use.
- FSM states: IDLE -> LATCH -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO, 16 times) -> UPDATE -> IDLE.
- IDLE: count POLL_CYC cycles, then enter LATCH.
- LATCH: pad_latch=1 for 2*HALF_CYC cycles, then drop pad_latch and enter SHIFT_LO with bit index 0.
- SHIFT_LO: pad_clk=0 for HALF_CYC cycles.
  - On the last cycle, store the synchronized data into shift bit[index].
  - The sample point is HALF_CYC cycles after the previous edge, so sync latency (2) is absorbed.
- SHIFT_HI: pad_clk=1 for HALF_CYC cycles; the rising edge advances the pad. Increment index; after index 15 go to UPDATE.
- Frame length from LATCH entry to UPDATE entry is exactly 34*HALF_CYC cycles.
- SNES bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 ID.
- UPDATE (1 cycle): frame_done=1.
  - Valid frame (bits 12-15 all 1): pad_present=1 and outputs are loaded.
  - Direction mapping: up=Up, dw=Down, lf=Left, rg=Right.
  - Button mapping: a=Y, b=B, c=A, x=L, y=X, z=R, st=Start, md=Select.
  - Polarity: pad-low stays output-low.
- Invalid frame (any ID bit 0): pad_present=0; all twelve outputs forced to 1 (released).
- Missing pad: a floating or pulled-up pad_data reads all 1s, which is valid and releases all buttons. No special case.
- Opposing directions: Up+Down or Left+Right pressed together are forwarded unchanged; the encoder owns any SOCD policy.
- Outputs change only in UPDATE. They are stable for at least POLL_CYC+34*HALF_CYC cycles, so the encoder never sees a partial frame.
- Mid-frame reset: all outputs return to reset values immediately; no partial shift data reaches the outputs.
- Timing: pad_latch and pad_clk are driven from registers (glitch-free). Counter widths are derived from the parameters with $clog2.

Test Plan:
- HALF_CYC=4, POLL_CYC=100, pad model shifting 16'hFFFF (all released):
  - pad_latch high for 8 cycles, 16 pad_clk low pulses of 4 cycles each.
  - frame_done 136 cycles after pad_latch rises.
  - pad_present=1, all outputs 1.
- Pad presses Y and Start (bits 1 and 3 low, ID bits 1):
  - After frame_done, a=0 and st=0, others 1.
  - Next frame with all released -> a=1, st=1 one cycle after frame_done.
- Pad drives ID bits 12-15 = 0 with Up pressed -> pad_present=0, up=1, all outputs 1.
- Each of the twelve buttons pressed singly -> only the mapped output is 0. Checks all bit-to-port mappings, including md=Select, x=L, z=R.
- Assert rst_n low mid-SHIFT (bit 7) while the pad has Up pressed:
  - Outputs return to reset values asynchronously; pad_clk=1, pad_latch=0.
  - After release, the first frame_done arrives 100+136 cycles later with up=0.
- pad_data toggling randomly during IDLE and LATCH:
  - Outputs do not change until frame_done.
  - Sampled bits equal the values held at each SHIFT_LO end.
